frame_sequencer: RTL and testbench
==================================

// Module: frame_sequencer
// PURPOSE
//  APU frame counter ($4017). Divides clk into quarter/half-frame step events.
//  Drives enable_240hz (envelope/linear) and enable_120hz (length/sweep) to all channels.
//  Implements the 4-step / 5-step mode schedule and the frame IRQ flag.
// PARAMETERS
//  STEP_TICKS  7457  clk cycles per sequencer step (1.79 MHz clk -> ~240 Hz); min 2
// PORTS
//  clk           in   1  system clock, APU rate
//  rst           in   1  asynchronous, active-high reset
//  reg_4017      in   8  [7]=mode (0: 4-step, 1: 5-step), [6]=IRQ inhibit; stable when reg_change toggles
//  reg_change    in   1  toggles once per $4017 write; asynchronous to clk
//  irq_ack       in   1  one-clk pulse, clears frame_irq ($4015 read)
//  enable_240hz  out  1  quarter-frame strobe, one clk wide
//  enable_120hz  out  1  half-frame strobe, one clk wide
//  frame_irq     out  1  sticky frame interrupt flag
// BEHAVIOUR
//  Reset (async): divider=0, step=0, mode=0, inhibit=0, sync flops=0, all outputs 0.
//  Write detect: 2-flop synchronizer on reg_change; reload=1 for one clk when the stages differ.
//   Latency: toggle sampled -> reload registered 3 clk later.
//  On reload: latch mode and inhibit from reg_4017; divider=0; step=0.
//   Inhibit=1 -> frame_irq cleared on the same edge.
//   New mode=1 -> enable_240hz and enable_120hz pulse together on the clk after reload.
//   New mode=0 -> no immediate pulse.
//  Divider: 0..STEP_TICKS-1, wraps to 0. At terminal count a step event fires.
//   Step event then advances step (mode 0: 0->1->2->3->0; mode 1: 0->1->2->3->4->0).
//  Step event decode, using step before advance, outputs registered (1 clk after terminal):
//   mode 0: step 0,2 -> 240 only; step 1,3 -> 240+120; step 3 -> set frame_irq unless inhibit.
//   mode 1: step 0,2 -> 240 only; step 1,4 -> 240+120; step 3 -> nothing; never sets IRQ.
//  frame_irq: set by the step-3 event (mode 0, !inhibit); cleared by irq_ack or a reload with inhibit=1.
//  Simultaneous cases:
//   reload + terminal count: reload wins; that step event is discarded.
//   irq set + irq_ack same clk: set wins, frame_irq stays 1.
//   irq set + reload with inhibit=1: clear wins.
//  Strobes never exceed one clk; no two step events closer than STEP_TICKS clk.
//  Reset mid-operation: outputs drop immediately (async). Schedule restarts at step 0, mode 0.
//  Widths: divider $clog2(STEP_TICKS) bits; step 3 bits; no overflow beyond stated wraps.
// CONFIGURATION
//  FRAME_IRQ_EN defined: frame_irq flag, inhibit bit and irq_ack logic built as above.
//  FRAME_IRQ_EN undefined: frame_irq tied 0; irq_ack and reg_4017[6] ignored.
//   Strobe schedule unchanged.
// TESTING (sim with STEP_TICKS=4, FRAME_IRQ_EN defined)
//  Reset release, no writes -> 240 pulses every 4 clk; 120 on every 2nd; frame_irq=1 after 4th 240 pulse.
//  Toggle reg_change with reg_4017=8'h80 -> 3 clk later reload; next clk both strobes.
//   Then 240 at steps 0,1,2,4 and none at step 3 (gap of 8 clk); frame_irq stays 0.
//  frame_irq=1, pulse irq_ack -> frame_irq=0 next clk. Ack coincident with step-3 set -> frame_irq remains 1.
//  Write reg_4017=8'h40 while frame_irq=1 -> frame_irq=0 on reload edge; no IRQ on later step 3.
//  Reload coincident with terminal count -> no strobe that cycle; next 240 exactly 4 clk after reload.
//  Assert rst mid-step with strobe high -> all outputs 0 same cycle; after release, mode 0 schedule from step 0.

Source files
------------

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - APU frame counter producing quarter/half-frame strobes and the frame IRQ
//
// Purpose:
//   Divides clk into sequencer steps of STEP_TICKS cycles. The 4-step or 5-step
//   schedule chooses which steps emit the quarter-frame strobe (enable_240hz) and
//   the half-frame strobe (enable_120hz). In 4-step mode, step 3 raises the sticky
//   frame IRQ. A $4017 write is signalled by a toggle on reg_change. That toggle is
//   synchronised, and it then restarts the schedule with the newly written mode.
//
// Configuration:
//   FRAME_IRQ_EN defined   : frame_irq, the inhibit bit reg_4017[6] and irq_ack are built.
//   FRAME_IRQ_EN undefined : frame_irq is tied 0; irq_ack and reg_4017[6] are ignored.
//
// Ports:
//   clk           in   system clock, APU rate
//   rst           in   asynchronous active-high reset
//   reg_4017[7:0] in   [7]=mode (0: 4-step, 1: 5-step), [6]=IRQ inhibit
//   reg_change    in   toggles once per $4017 write, asynchronous to clk
//   irq_ack       in   one-clk pulse that clears frame_irq
//   enable_240hz  out  quarter-frame strobe, one clk wide
//   enable_120hz  out  half-frame strobe, one clk wide
//   frame_irq     out  sticky frame interrupt flag
module frame_sequencer #(
  parameter int STEP_TICKS = 7457
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_4017,
  input  logic       reg_change,
  input  logic       irq_ack,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq
);

  localparam int DIV_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_TICKS - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } step_e;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic             reload_q, reload_d;
  logic [DIV_W-1:0] div_q, div_d;
  step_e            step_q, step_d;
  logic             mode_q, mode_d;
  logic             en240_q, en240_d;
  logic             en120_q, en120_d;
  logic             terminal;
  logic             irq_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      reload_q <= 1'b0;
      div_q    <= '0;
      step_q   <= STEP0;
      mode_q   <= 1'b0;
      en240_q  <= 1'b0;
      en120_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      reload_q <= reload_d;
      div_q    <= div_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
      en240_q  <= en240_d;
      en120_q  <= en120_d;
    end
  end

  always_comb begin
    // sync1/sync2 form the synchroniser; sync3 holds the previous synchronised
    // level, so a difference between sync2 and sync3 marks exactly one write.
    sync1_d  = reg_change;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    reload_d = sync2_q ^ sync3_q;

    div_d    = div_q;
    step_d   = step_q;
    mode_d   = mode_q;
    en240_d  = 1'b0;
    en120_d  = 1'b0;
    irq_set  = 1'b0;
    terminal = (div_q == DIV_LAST);

    if (reload_q) begin
      // A write restarts the schedule. A step event due on the same edge is dropped.
      mode_d = reg_4017[7];
      div_d  = '0;
      step_d = STEP0;
      if (reg_4017[7]) begin
        en240_d = 1'b1;
        en120_d = 1'b1;
      end
    end else begin
      div_d = terminal ? '0 : div_q + DIV_ONE;
      if (terminal) begin
        case (step_q)
          STEP0, STEP2: en240_d = 1'b1;
          STEP1, STEP4: begin
            en240_d = 1'b1;
            en120_d = 1'b1;
          end
          STEP3: begin
            // Step 3 is silent in 5-step mode.
            if (!mode_q) begin
              en240_d = 1'b1;
              en120_d = 1'b1;
              irq_set = 1'b1;
            end
          end
          default: ;
        endcase
        case (step_q)
          STEP0:   step_d = STEP1;
          STEP1:   step_d = STEP2;
          STEP2:   step_d = STEP3;
          STEP3:   step_d = mode_q ? STEP4 : STEP0;
          default: step_d = STEP0;
        endcase
      end
    end
  end

  assign enable_240hz = en240_q;
  assign enable_120hz = en120_q;

`ifdef FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q, irq_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  // Priority, lowest to highest: ack clear, step-3 set, reload-with-inhibit clear.
  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    if (reload_q) inhibit_d = reg_4017[6];
    if (irq_ack) irq_d = 1'b0;
    if (irq_set && !inhibit_q) irq_d = 1'b1;
    if (reload_q && reg_4017[6]) irq_d = 1'b0;
  end

  assign frame_irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_ack, reg_4017[6], irq_set};
  assign frame_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - randomized self-checking bench for frame_sequencer against a schedule model
module tb_frame_sequencer;

  localparam int ST = 4;
`ifdef FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg_4017;
  logic       reg_change;
  logic       irq_ack;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;

  frame_sequencer #(.STEP_TICKS(ST)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_4017     (reg_4017),
    .reg_change   (reg_change),
    .irq_ack      (irq_ack),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // The model counts edges since the schedule was last anchored, which happens at
  // a reset release or at a reload. Every ST edges there is one step event.
  int   edge_idx = 0;
  int   m_anchor = 0;
  bit   m_mode   = 1'b0;
  bit   m_inh    = 1'b0;
  bit   m_irq    = 1'b0;
  bit   exp240   = 1'b0;
  bit   exp120   = 1'b0;
  int   reload_edges[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_idx);
    end
  endtask

  // Returns 1 if the next edge is a 4-step step-3 event that would set the IRQ.
  function automatic bit next_is_irq_set();
    int k;
    k = edge_idx + 1 - m_anchor;
    return (reload_edges.size() == 0) && !m_mode && !m_inh &&
           (k % ST == 0) && (((k / ST) - 1) % 4 == 3);
  endfunction

  task automatic tick();
    bit set;
    bit ack;
    int k;
    int s;
    ack = irq_ack;
    @(posedge clk);
    edge_idx++;
    exp240 = 1'b0;
    exp120 = 1'b0;
    set    = 1'b0;
    if (reload_edges.size() > 0 && reload_edges[0] == edge_idx) begin
      void'(reload_edges.pop_front());
      m_mode   = reg_4017[7];
      m_anchor = edge_idx;
      if (m_mode) begin
        exp240 = 1'b1;
        exp120 = 1'b1;
      end
      if (IRQ_EN) begin
        m_inh = reg_4017[6];
        if (ack) m_irq = 1'b0;
        if (m_inh) m_irq = 1'b0;
      end
    end else begin
      k = edge_idx - m_anchor;
      if (k % ST == 0) begin
        s = ((k / ST) - 1) % (m_mode ? 5 : 4);
        if (!m_mode) begin
          exp240 = 1'b1;
          exp120 = (s == 1) || (s == 3);
          set    = (s == 3);
        end else begin
          exp240 = (s != 3);
          exp120 = (s == 1) || (s == 4);
        end
      end
      if (IRQ_EN) begin
        if (ack) m_irq = 1'b0;
        if (set && !m_inh) m_irq = 1'b1;
      end
    end
    #1;
    check_eq("enable_240hz", int'(enable_240hz), int'(exp240));
    check_eq("enable_120hz", int'(enable_120hz), int'(exp120));
    check_eq("frame_irq", int'(frame_irq), int'(m_irq));
    irq_ack = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // The toggle is sampled on the next edge. The reload takes effect 3 edges after that.
  task automatic write_4017(input logic [7:0] v);
    reg_4017   = v;
    reg_change = ~reg_change;
    reload_edges.push_back(edge_idx + 4);
  endtask

  task automatic apply_reset();
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_240_async", int'(enable_240hz), 0);
    check_eq("rst_120_async", int'(enable_120hz), 0);
    check_eq("rst_irq_async", int'(frame_irq), 0);
    reg_change = 1'b0;
    irq_ack    = 1'b0;
    reload_edges.delete();
    m_mode = 1'b0;
    m_inh  = 1'b0;
    m_irq  = 1'b0;
    repeat (2) begin
      @(posedge clk);
      edge_idx++;
    end
    #1;
    rst      = 1'b0;
    m_anchor = edge_idx;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (reload_edges.size() > 0 && guard < 10) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    bit found;
    rst        = 1'b1;
    reg_4017   = 8'h00;
    reg_change = 1'b0;
    irq_ack    = 1'b0;
    #1;
    check_eq("reset_240", int'(enable_240hz), 0);
    check_eq("reset_120", int'(enable_120hz), 0);
    check_eq("reset_irq", int'(frame_irq), 0);
    repeat (2) begin
      @(posedge clk);
      edge_idx++;
    end
    #1;
    rst      = 1'b0;
    m_anchor = edge_idx;

    // Free-running 4-step schedule from reset.
    run(40);

    // Acknowledge the pending IRQ.
    irq_ack = 1'b1;
    tick();
    run(3);

    // Switch to 5-step mode.
    write_4017(8'h80);
    run(50);

    // Back to 4-step mode, then land an ack on the step-3 set edge.
    write_4017(8'h00);
    drain();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (next_is_irq_set()) found = 1'b1;
      else tick();
    end
    check_eq("find_irq_set_edge", int'(found), 1);
    irq_ack = 1'b1;
    tick();
    run(3);

    // Inhibit write while the IRQ is pending.
    write_4017(8'h40);
    run(40);

    // Make the reload land on a terminal-count edge.
    write_4017(8'h00);
    drain();
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if ((edge_idx + 4 - m_anchor) % ST == 0) found = 1'b1;
      else tick();
    end
    check_eq("find_terminal_align", int'(found), 1);
    write_4017(8'h00);
    run(16);

    // Reset while a strobe is high.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (exp240) found = 1'b1;
    end
    check_eq("find_strobe_high", int'(found), 1);
    apply_reset();
    run(24);

    // Random writes and acks.
    for (int i = 0; i < 2000; i++) begin
      if (reload_edges.size() == 0 && $urandom_range(0, 29) == 0)
        write_4017({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 63))});
      if ($urandom_range(0, 9) == 0) irq_ack = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
